sram_mem_controller: RTL and testbench

Sequences data-memory accesses of the pipelined ARM core's MEM stage onto an external 16-bit asynchronous SRAM. Each 32-bit load or store becomes two half-word SRAM cycles with programmable wait states. While an access is in flight the block deasserts `ready`, which the top level uses to freeze every pipeline stage. It sits between the EXEC/MEM pipeline register outputs and the SRAM pins, in place of a single-cycle data memory.

---
 rtl/sram_mem_controller_if.sv | 27 ++
 rtl/sram_mem_controller.sv | 140 ++++++++++++++
 tb/tb_sram_mem_controller.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_mem_controller_if.sv
// Bundle of pipeline-side and SRAM-pad signals for sram_mem_controller.
// slave = the controller, master = the pipeline/pad side driving it.
interface sram_mem_controller_if #(
   parameter int ADDR_W = 18
);
   logic              mem_r_en;
   logic              mem_w_en;
   logic [31:0]       address;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ready;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_o;
   logic [15:0]       sram_dq_i;
   logic              sram_dq_oe;
   logic              sram_we_n;

   modport slave (
      input  mem_r_en, mem_w_en, address, wdata, sram_dq_i,
      output rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );

   modport master (
      output mem_r_en, mem_w_en, address, wdata, sram_dq_i,
      input  rdata, ready, sram_addr, sram_dq_o, sram_dq_oe, sram_we_n
   );
endinterface

// File: rtl/sram_mem_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit async SRAM cycles with wait states.
// Optional SRAM_LAST_READ_EN adds a one-entry last-read buffer that short-circuits repeat loads.
module sram_mem_controller #(
   parameter int ADDR_W      = 18,
   parameter int WAIT_CYCLES = 1
) (
   input logic                   clk,
   input logic                   rst,
   sram_mem_controller_if.slave  bus
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_LO   = 2'd1;
   localparam logic [1:0] S_HI   = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   // Counter is 5 bits so P-1 = 16 still fits when WAIT_CYCLES = 15.
   localparam logic [4:0] WE_LAST  = 5'(WAIT_CYCLES);
   localparam logic [4:0] CNT_LAST = 5'(WAIT_CYCLES + 1);

   logic [1:0]        r_state;
   logic [4:0]        r_cnt;
   logic              r_write;
   logic [ADDR_W-2:0] r_idx;
   logic [31:0]       r_wdata;
   logic [15:0]       r_lo;
   logic [31:0]       r_rdata;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_dq_o;
   logic              r_oe;
   logic              r_we_n;

   logic              w_req;
   logic [ADDR_W-2:0] w_idx;
   logic              w_hit;
   logic [31:0]       w_hit_data;
   logic              w_phase_end;
   logic              w_unused;

   assign w_req       = bus.mem_r_en | bus.mem_w_en;
   assign w_idx       = bus.address[ADDR_W:2];
   assign w_phase_end = (r_state == S_LO || r_state == S_HI) && (r_cnt == CNT_LAST);
   assign w_unused    = &{1'b0, bus.address[31:ADDR_W+1], bus.address[1:0]};

`ifdef SRAM_LAST_READ_EN
   logic              r_lr_valid;
   logic [ADDR_W-2:0] r_lr_idx;
   logic [31:0]       r_lr_data;

   assign w_hit      = bus.mem_r_en && !bus.mem_w_en && r_lr_valid && (r_lr_idx == w_idx);
   assign w_hit_data = r_lr_data;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lr_valid <= 1'b0;
      end else if (r_state == S_IDLE && bus.mem_w_en && r_lr_idx == w_idx) begin
         r_lr_valid <= 1'b0;
      end else if (w_phase_end && r_state == S_HI && !r_write) begin
         r_lr_valid <= 1'b1;
      end
   end

   // NOTE: index/data need no reset; r_lr_valid gates every use of them.
   always_ff @(posedge clk) begin
      if (w_phase_end && r_state == S_HI && !r_write) begin
         r_lr_idx  <= r_idx;
         r_lr_data <= {bus.sram_dq_i, r_lo};
      end
   end
`else
   assign w_hit      = 1'b0;
   assign w_hit_data = 32'h0;
`endif

   // NOTE: all state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_write <= 1'b0;
         r_idx   <= '0;
         r_wdata <= '0;
         r_lo    <= '0;
         r_rdata <= '0;
         r_addr  <= '0;
         r_dq_o  <= '0;
         r_oe    <= 1'b0;
         r_we_n  <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_write <= bus.mem_w_en;
                  r_idx   <= w_idx;
                  r_wdata <= bus.wdata;
                  if (w_hit) begin
                     r_state <= S_DONE;
                     r_rdata <= w_hit_data;
                  end else begin
                     r_state <= S_LO;
                     r_cnt   <= '0;
                     r_addr  <= {w_idx, 1'b0};
                     r_oe    <= bus.mem_w_en;
                     r_we_n  <= !bus.mem_w_en;
                     if (bus.mem_w_en) r_dq_o <= bus.wdata[15:0];
                  end
               end
            end
            S_LO, S_HI: begin
               r_cnt <= r_cnt + 5'd1;
               // Last cycle of each phase is the write hold/recovery cycle.
               if (r_cnt == WE_LAST) r_we_n <= 1'b1;
               if (r_cnt == CNT_LAST) begin
                  r_cnt <= '0;
                  if (r_state == S_LO) begin
                     r_lo    <= bus.sram_dq_i;
                     r_state <= S_HI;
                     r_addr  <= {r_idx, 1'b1};
                     r_we_n  <= !r_write;
                     if (r_write) r_dq_o <= r_wdata[31:16];
                  end else begin
                     r_state <= S_DONE;
                     if (!r_write) r_rdata <= {bus.sram_dq_i, r_lo};
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_oe    <= 1'b0;
            end
         endcase
      end
   end

   assign bus.ready      = (r_state == S_DONE) || (r_state == S_IDLE && !w_req);
   assign bus.rdata      = r_rdata;
   assign bus.sram_addr  = r_addr;
   assign bus.sram_dq_o  = r_dq_o;
   assign bus.sram_dq_oe = r_oe;
   assign bus.sram_we_n  = r_we_n;
endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller: WAIT_CYCLES=1 and WAIT_CYCLES=0 instances behind a shared driver.
// Define SRAM_LAST_READ_EN at compile time to expect buffered-read timing.
module tb_sram_mem_controller;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst1, rst0, sel;
   logic        tb_r, tb_w;
   logic [31:0] tb_addr, tb_wdata;
   int          n_total = 0;
   int          n_pass  = 0;
   int          viol    = 0;
   logic        mon_en  = 1'b0;
   longint      last_done;

`ifdef SRAM_LAST_READ_EN
   localparam int HIT_STALL = 1;
`else
   localparam int HIT_STALL = 7;
`endif

   sram_mem_controller_if #(.ADDR_W(18)) if1 ();
   sram_mem_controller_if #(.ADDR_W(18)) if0 ();

   sram_mem_controller #(.ADDR_W(18), .WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst1), .bus(if1.slave));
   sram_mem_controller #(.ADDR_W(18), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst0), .bus(if0.slave));

   assign if1.mem_r_en = sel ? tb_r : 1'b0;
   assign if1.mem_w_en = sel ? tb_w : 1'b0;
   assign if1.address  = tb_addr;
   assign if1.wdata    = tb_wdata;
   assign if0.mem_r_en = sel ? 1'b0 : tb_r;
   assign if0.mem_w_en = sel ? 1'b0 : tb_w;
   assign if0.address  = tb_addr;
   assign if0.wdata    = tb_wdata;

   // Async SRAM models: combinational read, write while we_n is low.
   logic [15:0] mem1 [1024];
   logic [15:0] mem0 [1024];
   assign if1.sram_dq_i = mem1[if1.sram_addr[9:0]];
   assign if0.sram_dq_i = mem0[if0.sram_addr[9:0]];
   always @(posedge clk) begin
      if (!if1.sram_we_n) mem1[if1.sram_addr[9:0]] <= if1.sram_dq_o;
      if (!if0.sram_we_n) mem0[if0.sram_addr[9:0]] <= if0.sram_dq_o;
   end

   logic        m_ready, m_we, m_oe;
   logic [31:0] m_rdata;
   logic [17:0] m_addr;
   logic [15:0] m_dq;
   assign m_ready = sel ? if1.ready      : if0.ready;
   assign m_we    = sel ? if1.sram_we_n  : if0.sram_we_n;
   assign m_oe    = sel ? if1.sram_dq_oe : if0.sram_dq_oe;
   assign m_rdata = sel ? if1.rdata      : if0.rdata;
   assign m_addr  = sel ? if1.sram_addr  : if0.sram_addr;
   assign m_dq    = sel ? if1.sram_dq_o  : if0.sram_dq_o;

   // Pad outputs must be stable while we_n is low; address may only move after a we_n-high cycle.
   logic        p_we = 1'b1, p_oe = 1'b0;
   logic [17:0] p_addr = '0;
   logic [15:0] p_dq = '0;
   always @(negedge clk) begin
      if (mon_en && !p_we && (m_addr !== p_addr || m_dq !== p_dq || m_oe !== p_oe)) viol++;
      p_we   = m_we;
      p_oe   = m_oe;
      p_addr = m_addr;
      p_dq   = m_dq;
   end

   logic [17:0] tr_addr [64];
   logic [15:0] tr_dq   [64];
   logic        tr_we   [64];
   logic        tr_oe   [64];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Present a request, count ready=0 cycles, return in the IDLE cycle after DONE.
   task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                         output int stall, output int we_low, output int oe_cyc, output logic [31:0] rd);
      stall = 0; we_low = 0; oe_cyc = 0; rd = '0;
      tb_r = r; tb_w = w; tb_addr = a; tb_wdata = d;
      for (int k = 0; k < 200; k++) begin
         #1;
         if (m_ready) break;
         if (stall < 64) begin
            tr_addr[stall] = m_addr;
            tr_dq[stall]   = m_dq;
            tr_we[stall]   = m_we;
            tr_oe[stall]   = m_oe;
         end
         stall++;
         if (!m_we) we_low++;
         if (m_oe) oe_cyc++;
         @(negedge clk);
      end
      if (!m_ready) begin
         n_total++;
         $display("FAIL access_timeout: ready stayed 0 for %0d cycles, required completion", stall);
      end
      rd = m_rdata;
      last_done = longint'($time);
      @(negedge clk);
   endtask

   task automatic idle();
      tb_r = 1'b0;
      tb_w = 1'b0;
      @(negedge clk);
   endtask

   typedef struct {
      logic        r, w;
      logic [31:0] addr, wdata, exp_rd;
      int          exp_stall, exp_we, exp_oe;
   } vec_t;

   vec_t        vecs [10];
   int          st, wl, oc;
   logic [31:0] rd;
   longint      t0;

   initial begin
      vecs[0] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, 7,         0, 0};
      vecs[1] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'hDEADBEEF, HIT_STALL, 0, 0};
      vecs[2] = '{1'b0, 1'b1, 32'h400, 32'h12345678, 32'hDEADBEEF, 7,         4, 6};
      vecs[3] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h12345678, 7,         0, 0};
      vecs[4] = '{1'b1, 1'b1, 32'h408, 32'hCAFEF00D, 32'h12345678, 7,         4, 6};
      vecs[5] = '{1'b1, 1'b0, 32'h408, 32'h0,        32'hCAFEF00D, 7,         0, 0};
      vecs[6] = '{1'b1, 1'b0, 32'h400, 32'h0,        32'h12345678, 7,         0, 0};
      vecs[7] = '{1'b0, 1'b1, 32'h000, 32'hA5A55A5A, 32'h12345678, 7,         4, 6};
      vecs[8] = '{1'b1, 1'b0, 32'h000, 32'h0,        32'hA5A55A5A, 7,         0, 0};
      vecs[9] = '{1'b1, 1'b0, 32'h000, 32'h0,        32'hA5A55A5A, HIT_STALL, 0, 0};

      sel = 1'b1; tb_r = 1'b0; tb_w = 1'b0; tb_addr = '0; tb_wdata = '0;
      rst1 = 1'b0; rst0 = 1'b0;
      #12;
      check("rst_ready", 32'(m_ready), 32'd1);
      check("rst_we_n",  32'(m_we),    32'd1);
      check("rst_oe",    32'(m_oe),    32'd0);
      check("rst_addr",  32'(m_addr),  32'd0);
      check("rst_dq_o",  32'(m_dq),    32'd0);
      check("rst_rdata", m_rdata,      32'd0);
      @(negedge clk); rst1 = 1'b1; rst0 = 1'b1;
      @(negedge clk); #1 mon_en = 1'b1;

      // Store 0xDEADBEEF to 0x400: per-cycle pad trace.
      access(1'b0, 1'b1, 32'h400, 32'hDEADBEEF, st, wl, oc, rd);
      check("st_stall", 32'(st), 32'd7);
      check("st_we_low", 32'(wl), 32'd4);
      check("st_rdata", rd, 32'd0);
      for (int k = 0; k < 7; k++) begin
         check($sformatf("st_we[%0d]", k), 32'(tr_we[k]), 32'(!(k == 1 || k == 2 || k == 4 || k == 5)));
         check($sformatf("st_oe[%0d]", k), 32'(tr_oe[k]), 32'(k >= 1));
         if (k >= 1) begin
            check($sformatf("st_addr[%0d]", k), 32'(tr_addr[k]), (k <= 3) ? 32'h200 : 32'h201);
            check($sformatf("st_dq[%0d]", k),   32'(tr_dq[k]),   (k <= 3) ? 32'hBEEF : 32'hDEAD);
         end
      end
      idle();

      for (int i = 0; i < 10; i++) begin
         access(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wdata, st, wl, oc, rd);
         check($sformatf("v%0d_stall", i), 32'(st), 32'(vecs[i].exp_stall));
         check($sformatf("v%0d_we_low", i), 32'(wl), 32'(vecs[i].exp_we));
         check($sformatf("v%0d_oe", i), 32'(oc), 32'(vecs[i].exp_oe));
         check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rd);
         idle();
         #1 check($sformatf("v%0d_rdata_held", i), m_rdata, vecs[i].exp_rd);
      end

      // WAIT_CYCLES=0: back-to-back store then load of 0x404.
      mon_en = 1'b0; sel = 1'b0;
      @(negedge clk); #1 mon_en = 1'b1;
      access(1'b0, 1'b1, 32'h404, 32'h0BADF00D, st, wl, oc, rd);
      check("w0_st_stall", 32'(st), 32'd5);
      check("w0_st_we_low", 32'(wl), 32'd2);
      check("w0_st_oe", 32'(oc), 32'd4);
      t0 = last_done;
      access(1'b1, 1'b0, 32'h404, 32'h0, st, wl, oc, rd);
      check("w0_ld_stall", 32'(st), 32'd5);
      check("w0_ld_rdata", rd, 32'h0BADF00D);
      check("w0_ld_we_low", 32'(wl), 32'd0);
      check("w0_gap", 32'(last_done - t0), 32'd60);
      check("w0_idle_addr", 32'(tr_addr[0]), 32'h203);
      check("w0_idle_oe", 32'(tr_oe[0]), 32'd0);
      check("w0_lo_addr", 32'(tr_addr[1]), 32'h202);
      idle();

      // Reset during the 2nd HI cycle of a store.
      mon_en = 1'b0; sel = 1'b1;
      @(negedge clk);
      tb_w = 1'b1; tb_addr = 32'h40C; tb_wdata = 32'h11112222;
      repeat (5) @(negedge clk);
      #1 check("rst_mid_pre_we", 32'(m_we), 32'd0);
      #1 rst1 = 1'b0; tb_w = 1'b0;
      #1;
      check("rst_mid_we_n", 32'(m_we), 32'd1);
      check("rst_mid_oe", 32'(m_oe), 32'd0);
      check("rst_mid_ready", 32'(m_ready), 32'd1);
      check("rst_mid_addr", 32'(m_addr), 32'd0);
      check("rst_mid_rdata", m_rdata, 32'd0);
      @(negedge clk); rst1 = 1'b1;
      @(negedge clk); #1 mon_en = 1'b1;
      access(1'b0, 1'b1, 32'h40C, 32'h11112222, st, wl, oc, rd);
      check("post_rst_stall", 32'(st), 32'd7);
      check("post_rst_lo_addr", 32'(tr_addr[1]), 32'h206);
      check("post_rst_lo_we", 32'(tr_we[1]), 32'd0);
      idle();
      access(1'b1, 1'b0, 32'h40C, 32'h0, st, wl, oc, rd);
      check("post_rst_ld_rdata", rd, 32'h11112222);
      check("post_rst_ld_stall", 32'(st), 32'd7);
      idle();

      check("pad_stable_under_we", 32'(viol), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
